// File: rtl/thor2024_regfile_valid.sv
`default_nettype none
// ============================================================================
//  Module   : thor2024_regfile_valid
//  Purpose  : Register-valid scoreboard kept alongside the rf_source rename
//             tracker. One bit per architectural register:
//               1 = value lives in the register file
//               0 = a queued IQ entry will produce it
//             Bits are cleared when writers enqueue, set when the latest
//             writer commits, and rebuilt from livetarget on a branch miss.
//  Ports    : clk, rst (async, active-low)
//             enqueue : tail0/1, iq_v_tail0/1, fetchbuf0_v/1_v,
//                       fetchbuf0_rfw/1_rfw, fetchbuf0_bb, Rt0, Rt1
//             flush   : branchmiss, livetarget
//             commit  : commit0_v/1_v, commit0_rfw/1_rfw, commit0_id/1_id,
//                       commit0_tgt/1_tgt, rf_source
//             outputs : rf_v (registered valid bits),
//                       pend_cnt (registered count of rf_v==0)
//  Revision : 1.0  initial release
// ============================================================================
module thor2024_regfile_valid #(
   parameter int AREGS    = 64,
   parameter int QENTRIES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(QENTRIES)-1:0]   tail0,
   input  logic [$clog2(QENTRIES)-1:0]   tail1,
   input  logic                          iq_v_tail0,
   input  logic                          iq_v_tail1,
   input  logic                          fetchbuf0_v,
   input  logic                          fetchbuf1_v,
   input  logic                          fetchbuf0_rfw,
   input  logic                          fetchbuf1_rfw,
   input  logic                          fetchbuf0_bb,
   input  logic [$clog2(AREGS)-1:0]      Rt0,
   input  logic [$clog2(AREGS)-1:0]      Rt1,
   input  logic                          branchmiss,
   input  logic [AREGS-1:0]              livetarget,
   input  logic                          commit0_v,
   input  logic                          commit1_v,
   input  logic                          commit0_rfw,
   input  logic                          commit1_rfw,
   input  logic [$clog2(QENTRIES)-1:0]   commit0_id,
   input  logic [$clog2(QENTRIES)-1:0]   commit1_id,
   input  logic [$clog2(AREGS)-1:0]      commit0_tgt,
   input  logic [$clog2(AREGS)-1:0]      commit1_tgt,
   input  logic [AREGS-1:0][4:0]         rf_source,
   output logic [AREGS-1:0]              rf_v,
   output logic [$clog2(AREGS):0]        pend_cnt
);

   localparam int c_CNT_W = $clog2(AREGS) + 1;
   localparam logic [AREGS-1:0] c_ONE = {{(AREGS-1){1'b0}}, 1'b1};

   logic [AREGS-1:0]   r_rf_v;
   logic [c_CNT_W-1:0] r_pend_cnt;

   logic               w_clr0;
   logic               w_clr1;
   logic               w_set0;
   logic               w_set1;
   logic [AREGS-1:0]   w_base;
   logic [AREGS-1:0]   w_clr_mask;
   logic [AREGS-1:0]   w_set_mask;
   logic [AREGS-1:0]   w_next;
   logic [c_CNT_W-1:0] w_cnt;
   logic               w_unused;

   // Slot tags and the spare rf_source bit are not needed to decide validity.
   assign w_unused = ^{tail0, tail1, rf_source};

   // Enqueue decode follows the rename-table update: a pair only enqueues
   // when fetchbuf0 is not a backward branch and slot tail0 is free; the
   // second instruction additionally needs tail1 free.
   always_comb begin
      w_clr0 = 1'b0;
      w_clr1 = 1'b0;
      if (!branchmiss) begin
         if (!fetchbuf0_v && fetchbuf1_v) begin
            w_clr1 = !iq_v_tail0 && fetchbuf1_rfw;
         end else if (fetchbuf0_v && fetchbuf1_v && !fetchbuf0_bb && !iq_v_tail0) begin
            w_clr0 = fetchbuf0_rfw;
            w_clr1 = !iq_v_tail1 && fetchbuf1_rfw;
         end
      end
   end

   // A commit only re-validates a register if it is still the latest writer.
   assign w_set0 = commit0_v && commit0_rfw &&
                   (rf_source[commit0_tgt][3:0] == 4'(commit0_id));
   assign w_set1 = commit1_v && commit1_rfw &&
                   (rf_source[commit1_tgt][3:0] == 4'(commit1_id));

   always_comb begin
      w_base     = branchmiss ? ~livetarget : r_rf_v;
      w_clr_mask = (w_clr0 ? (c_ONE << Rt0) : '0) |
                   (w_clr1 ? (c_ONE << Rt1) : '0);
      w_set_mask = (w_set0 ? (c_ONE << commit0_tgt) : '0) |
                   (w_set1 ? (c_ONE << commit1_tgt) : '0);
      // Enqueue clear beats commit set; register 0 is always valid.
      w_next     = (w_base | w_set_mask) & ~w_clr_mask;
      w_next[0]  = 1'b1;
   end

   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < AREGS; i++) begin
         w_cnt = w_cnt + {{(c_CNT_W-1){1'b0}}, ~w_next[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rf_v     <= '1;
         r_pend_cnt <= '0;
      end else begin
         r_rf_v     <= w_next;
         r_pend_cnt <= w_cnt;
      end
   end

   assign rf_v     = r_rf_v;
   assign pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_thor2024_regfile_valid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_thor2024_regfile_valid
//  Purpose  : Self-checking bench for thor2024_regfile_valid: directed table,
//             hand-written flush/reset sequences and a random run checked
//             against a per-register reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_thor2024_regfile_valid;

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       tail0, tail1;
   logic             iq_v_tail0, iq_v_tail1;
   logic             fetchbuf0_v, fetchbuf1_v, fetchbuf0_rfw, fetchbuf1_rfw, fetchbuf0_bb;
   logic [5:0]       Rt0, Rt1;
   logic             branchmiss;
   logic [63:0]      livetarget;
   logic             commit0_v, commit1_v, commit0_rfw, commit1_rfw;
   logic [2:0]       commit0_id, commit1_id;
   logic [5:0]       commit0_tgt, commit1_tgt;
   logic [63:0][4:0] rf_source;
   logic [63:0]      rf_v;
   logic [6:0]       pend_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   thor2024_regfile_valid #(.AREGS(64), .QENTRIES(8)) dut (
      .clk(clk), .rst(rst),
      .tail0(tail0), .tail1(tail1),
      .iq_v_tail0(iq_v_tail0), .iq_v_tail1(iq_v_tail1),
      .fetchbuf0_v(fetchbuf0_v), .fetchbuf1_v(fetchbuf1_v),
      .fetchbuf0_rfw(fetchbuf0_rfw), .fetchbuf1_rfw(fetchbuf1_rfw),
      .fetchbuf0_bb(fetchbuf0_bb),
      .Rt0(Rt0), .Rt1(Rt1),
      .branchmiss(branchmiss), .livetarget(livetarget),
      .commit0_v(commit0_v), .commit1_v(commit1_v),
      .commit0_rfw(commit0_rfw), .commit1_rfw(commit1_rfw),
      .commit0_id(commit0_id), .commit1_id(commit1_id),
      .commit0_tgt(commit0_tgt), .commit1_tgt(commit1_tgt),
      .rf_source(rf_source),
      .rf_v(rf_v), .pend_cnt(pend_cnt)
   );

   typedef struct {
      logic        f0v, f1v, f0w, f1w, bb, q0, q1;
      logic [5:0]  rt0, rt1;
      logic        cv;
      logic [2:0]  cid;
      logic [5:0]  ctgt;
      logic [63:0] exp_v;
      logic [6:0]  exp_p;
   } vec_t;

   vec_t tbl[13];

   function automatic logic [63:0] b(input int n);
      logic [63:0] one;
      one = 64'd1;
      return one << n;
   endfunction

   function automatic vec_t mk(input logic f0v, f1v, f0w, f1w, bb, q0, q1,
                               input int rt0, rt1, input logic cv, input int cid, ctgt,
                               input logic [63:0] pend_mask, input int p);
      vec_t v;
      v.f0v = f0v; v.f1v = f1v; v.f0w = f0w; v.f1w = f1w; v.bb = bb;
      v.q0 = q0; v.q1 = q1; v.rt0 = 6'(rt0); v.rt1 = 6'(rt1);
      v.cv = cv; v.cid = 3'(cid); v.ctgt = 6'(ctgt);
      v.exp_v = ~pend_mask; v.exp_p = 7'(p);
      return v;
   endfunction

   task automatic check_v(input string name, input logic [63:0] exp);
      total++;
      if (rf_v !== exp) begin
         bad++;
         $display("FAIL %s: rf_v got %h want %h", name, rf_v, exp);
      end
   endtask

   task automatic check_p(input string name, input logic [6:0] exp);
      total++;
      if (pend_cnt !== exp) begin
         bad++;
         $display("FAIL %s: pend_cnt got %0d want %0d", name, pend_cnt, exp);
      end
   endtask

   task automatic idle();
      tail0 = 3'd0; tail1 = 3'd1;
      iq_v_tail0 = 1'b0; iq_v_tail1 = 1'b0;
      fetchbuf0_v = 1'b0; fetchbuf1_v = 1'b0;
      fetchbuf0_rfw = 1'b0; fetchbuf1_rfw = 1'b0; fetchbuf0_bb = 1'b0;
      Rt0 = 6'd0; Rt1 = 6'd0;
      branchmiss = 1'b0; livetarget = '0;
      commit0_v = 1'b0; commit1_v = 1'b0; commit0_rfw = 1'b0; commit1_rfw = 1'b0;
      commit0_id = 3'd0; commit1_id = 3'd0; commit0_tgt = 6'd0; commit1_tgt = 6'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: walks every register and applies the behavioural
   // rules directly (who enqueues, who commits, which wins).
   logic [63:0] m_v;

   function automatic logic [63:0] model_next(input logic [63:0] cur);
      logic [63:0] nx;
      logic en0, en1, clr, set, base;
      en0 = 1'b0; en1 = 1'b0;
      if (!branchmiss) begin
         if ({fetchbuf0_v, fetchbuf1_v} == 2'b01) begin
            en1 = !iq_v_tail0 && fetchbuf1_rfw;
         end else if ({fetchbuf0_v, fetchbuf1_v} == 2'b11 && !fetchbuf0_bb && !iq_v_tail0) begin
            en0 = fetchbuf0_rfw;
            en1 = !iq_v_tail1 && fetchbuf1_rfw;
         end
      end
      for (int r = 0; r < 64; r++) begin
         base = branchmiss ? !livetarget[r] : cur[r];
         clr  = (en0 && int'(Rt0) == r) || (en1 && int'(Rt1) == r);
         set  = (commit0_v && commit0_rfw && int'(commit0_tgt) == r &&
                 int'(rf_source[r][3:0]) == int'(commit0_id)) ||
                (commit1_v && commit1_rfw && int'(commit1_tgt) == r &&
                 int'(rf_source[r][3:0]) == int'(commit1_id));
         if (r == 0)    nx[r] = 1'b1;
         else if (clr)  nx[r] = 1'b0;
         else if (set)  nx[r] = 1'b1;
         else           nx[r] = base;
      end
      return nx;
   endfunction

   function automatic logic [6:0] zeros(input logic [63:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 64; i++) if (!v[i]) n++;
      return 7'(n);
   endfunction

   initial begin
      idle();
      rf_source = '0;
      rf_source[5] = 5'd3;
      rf_source[9] = 5'd4;
      rf_source[7] = 5'd1;
      rf_source[10] = 5'd6;

      //          f0v f1v f0w f1w bb  q0  q1  rt0 rt1 cv  cid ctgt pending-mask               pend
      tbl[0]  = mk(0,  0,  0,  0,  0,  0,  0,   0,  0, 0,  0,  0, 64'd0,                      0);
      tbl[1]  = mk(1,  1,  1,  1,  0,  0,  0,   5,  9, 0,  0,  0, b(5)|b(9),                  2);
      tbl[2]  = mk(1,  0,  1,  0,  0,  0,  0,  12,  0, 0,  0,  0, b(5)|b(9),                  2);
      tbl[3]  = mk(0,  1,  0,  1,  0,  0,  0,   0, 12, 0,  0,  0, b(5)|b(9)|b(12),            3);
      tbl[4]  = mk(1,  1,  1,  0,  0,  0,  0,   7,  7, 0,  0,  0, b(5)|b(7)|b(9)|b(12),       4);
      tbl[5]  = mk(0,  0,  0,  0,  0,  0,  0,   0,  0, 1,  3,  5, b(7)|b(9)|b(12),            3);
      tbl[6]  = mk(0,  0,  0,  0,  0,  0,  0,   0,  0, 1,  2,  9, b(7)|b(9)|b(12),            3);
      tbl[7]  = mk(1,  1,  1,  1,  1,  0,  0,  20, 21, 0,  0,  0, b(7)|b(9)|b(12),            3);
      tbl[8]  = mk(1,  1,  1,  1,  0,  0,  1,  20, 21, 0,  0,  0, b(7)|b(9)|b(12)|b(20),      4);
      tbl[9]  = mk(0,  1,  0,  1,  0,  1,  0,   0, 22, 0,  0,  0, b(7)|b(9)|b(12)|b(20),      4);
      tbl[10] = mk(0,  1,  0,  1,  0,  0,  0,   0,  5, 1,  3,  5, b(5)|b(7)|b(9)|b(12)|b(20), 5);
      tbl[11] = mk(0,  1,  0,  1,  0,  0,  0,   0,  0, 0,  0,  0, b(5)|b(7)|b(9)|b(12)|b(20), 5);
      tbl[12] = mk(0,  0,  0,  0,  0,  0,  0,   0,  0, 1,  4,  9, b(5)|b(7)|b(12)|b(20),      4);

      // Reset held: all valid, nothing pending.
      rst = 1'b0;
      tick(); tick();
      check_v("reset_rf_v", '1);
      check_p("reset_pend", 7'd0);
      rst = 1'b1;

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         idle();
         fetchbuf0_v = tbl[i].f0v; fetchbuf1_v = tbl[i].f1v;
         fetchbuf0_rfw = tbl[i].f0w; fetchbuf1_rfw = tbl[i].f1w;
         fetchbuf0_bb = tbl[i].bb;
         iq_v_tail0 = tbl[i].q0; iq_v_tail1 = tbl[i].q1;
         Rt0 = tbl[i].rt0; Rt1 = tbl[i].rt1;
         commit0_v = tbl[i].cv; commit0_rfw = tbl[i].cv;
         commit0_id = tbl[i].cid; commit0_tgt = tbl[i].ctgt;
         tick();
         check_v($sformatf("vec%0d_rf_v", i), tbl[i].exp_v);
         check_p($sformatf("vec%0d_pend", i), tbl[i].exp_p);
      end

      // Branch miss: only reg 9 survives; a concurrent enqueue is dropped.
      idle();
      branchmiss = 1'b1; livetarget = b(9);
      fetchbuf0_v = 1'b1; fetchbuf1_v = 1'b1; fetchbuf0_rfw = 1'b1; fetchbuf1_rfw = 1'b1;
      Rt0 = 6'd30; Rt1 = 6'd31;
      tick();
      check_v("bmiss_rebuild", ~b(9));
      check_p("bmiss_pend", 7'd1);

      // Branch miss with commit set on top; livetarget bit 0 cannot clear reg 0.
      idle();
      branchmiss = 1'b1; livetarget = b(0) | b(9) | b(10);
      commit1_v = 1'b1; commit1_rfw = 1'b1; commit1_id = 3'd6; commit1_tgt = 6'd10;
      tick();
      check_v("bmiss_commit", ~b(9));
      check_p("bmiss_commit_pend", 7'd1);

      // Both ports on reg 9: port0 stale, port1 latest -> set.
      idle();
      commit0_v = 1'b1; commit0_rfw = 1'b1; commit0_id = 3'd2; commit0_tgt = 6'd9;
      commit1_v = 1'b1; commit1_rfw = 1'b1; commit1_id = 3'd4; commit1_tgt = 6'd9;
      tick();
      check_v("dual_commit", '1);
      check_p("dual_commit_pend", 7'd0);

      // Commit with rfw low must not set.
      idle();
      fetchbuf0_v = 1'b1; fetchbuf1_v = 1'b1; fetchbuf0_rfw = 1'b1; Rt0 = 6'd5;
      tick();
      idle();
      commit0_v = 1'b1; commit0_rfw = 1'b0; commit0_id = 3'd3; commit0_tgt = 6'd5;
      tick();
      check_v("commit_norfw", ~b(5));

      // Asynchronous reset in the middle of a cycle with events pending.
      idle();
      fetchbuf0_v = 1'b1; fetchbuf1_v = 1'b1; fetchbuf0_rfw = 1'b1; fetchbuf1_rfw = 1'b1;
      Rt0 = 6'd40; Rt1 = 6'd41;
      #2 rst = 1'b0;
      #1;
      check_v("async_reset", '1);
      check_p("async_reset_pend", 7'd0);
      tick();
      check_v("reset_dominates", '1);
      rst = 1'b1;
      tick();
      check_v("after_release", ~(b(40) | b(41)));
      check_p("after_release_pend", 7'd2);

      // Random run against the model.
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      m_v = '1;
      for (int c = 0; c < 400; c++) begin
         logic [63:0] exp_v;
         tail0 = 3'($urandom); tail1 = 3'($urandom);
         iq_v_tail0 = ($urandom_range(0, 3) == 0);
         iq_v_tail1 = ($urandom_range(0, 3) == 0);
         fetchbuf0_v = 1'($urandom); fetchbuf1_v = 1'($urandom);
         fetchbuf0_rfw = ($urandom_range(0, 3) != 0);
         fetchbuf1_rfw = ($urandom_range(0, 3) != 0);
         fetchbuf0_bb = ($urandom_range(0, 5) == 0);
         Rt0 = 6'($urandom_range(0, 15)); Rt1 = 6'($urandom_range(0, 15));
         branchmiss = ($urandom_range(0, 15) == 0);
         livetarget = {$urandom, $urandom} & {$urandom, $urandom};
         commit0_v = 1'($urandom); commit1_v = 1'($urandom);
         commit0_rfw = ($urandom_range(0, 3) != 0);
         commit1_rfw = ($urandom_range(0, 3) != 0);
         commit0_id = 3'($urandom); commit1_id = 3'($urandom);
         commit0_tgt = 6'($urandom_range(0, 15)); commit1_tgt = 6'($urandom_range(0, 15));
         for (int r = 0; r < 64; r++) rf_source[r] = 5'($urandom);
         if ($urandom_range(0, 1) == 1) rf_source[commit0_tgt] = {2'b00, commit0_id};
         if ($urandom_range(0, 1) == 1) rf_source[commit1_tgt] = {2'b00, commit1_id};
         exp_v = model_next(m_v);
         tick();
         m_v = exp_v;
         check_v($sformatf("rand%0d_rf_v", c), m_v);
         check_p($sformatf("rand%0d_pend", c), zeros(m_v));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
